// File: rtl/traffic_phase_scheduler_if.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler_if
//   Bundles the sensor/button requests going into the phase scheduler and the
//   lamp/status signals coming out of it.
//
//   Signals:
//     ns_req, ew_req   vehicle presence on the N/S and E/W approaches (level)
//     ped_req          pedestrian button (pulse or level)
//     flash            force flashing mode (only with TRAFFIC_FLASH_MODE_EN)
//     n/s/e/w_light    per-approach lamp code: GREEN=001 RED=010 YELLOW=100
//     walk             pedestrian walk lamp
//     phase            current scheduler state code
//
//   Modports:
//     master  the side that produces requests and watches the lamps
//     slave   the scheduler itself
//
//   Optional macro: TRAFFIC_FLASH_MODE_EN adds the flash signal.
// ---------------------------------------------------------------------------
interface traffic_phase_scheduler_if;
    logic       ns_req;
    logic       ew_req;
    logic       ped_req;
`ifdef TRAFFIC_FLASH_MODE_EN
    logic       flash;
`endif
    logic [2:0] n_light;
    logic [2:0] s_light;
    logic [2:0] e_light;
    logic [2:0] w_light;
    logic       walk;
    logic [2:0] phase;

    modport master (
        output ns_req, ew_req, ped_req,
`ifdef TRAFFIC_FLASH_MODE_EN
        output flash,
`endif
        input  n_light, s_light, e_light, w_light, walk, phase
    );

    modport slave (
        input  ns_req, ew_req, ped_req,
`ifdef TRAFFIC_FLASH_MODE_EN
        input  flash,
`endif
        output n_light, s_light, e_light, w_light, walk, phase
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
//   Demand-driven phase scheduler for the four-way intersection: minimum and
//   maximum green, gap-out, yellow, all-red clearance and a pedestrian
//   all-red walk phase. Lamp outputs are a pure decode of the state register.
//
//   Ports:
//     clk   system clock, everything on its rising edge
//     rst   synchronous reset, active low
//     bus   traffic_phase_scheduler_if.slave (requests in, lamps/status out)
//
//   Optional macro: TRAFFIC_FLASH_MODE_EN adds the flash input and the
//   FLASH state (code 6). Without it code 6 is illegal and recovers to AR.
// ---------------------------------------------------------------------------
module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 4
) (
    input logic                     clk,
    input logic                     rst,
    traffic_phase_scheduler_if.slave bus
);

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] RED    = 3'b010;
    localparam logic [2:0] YELLOW = 3'b100;

    localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR    = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
`ifdef TRAFFIC_FLASH_MODE_EN
        WALK  = 3'd5,
        FLASH = 3'd6
`else
        WALK  = 3'd5
`endif
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [CNT_W-1:0] cnt;
    logic            ns_pend;
    logic            ew_pend;
    logic            ped_pend;
    logic            last_dir;
    logic            pend_hold;
`ifdef TRAFFIC_FLASH_MODE_EN
    logic            flash_on;

    // Pending latches freeze while flashing is requested or active.
    assign pend_hold = bus.flash || (state == FLASH);
`else
    assign pend_hold = 1'b0;
`endif

    // Next-state selection. Green exits only once minimum green has elapsed
    // and something competes; the own-direction request extends green until
    // maximum green. All-red serves a waiting pedestrian first (a button press
    // landing in the exit cycle counts), otherwise the opposite direction.
    always_comb begin
        nxt = state;
        case (state)
            NS_G: if (cnt >= MIN_M1 && (ew_pend || ped_pend) &&
                      (!bus.ns_req || cnt >= MAX_M1)) nxt = NS_Y;
            NS_Y: if (cnt == YEL_M1) nxt = AR;
            EW_G: if (cnt >= MIN_M1 && (ns_pend || ped_pend) &&
                      (!bus.ew_req || cnt >= MAX_M1)) nxt = EW_Y;
            EW_Y: if (cnt == YEL_M1) nxt = AR;
            AR:   if (cnt == AR_M1) begin
                      if (ped_pend || bus.ped_req) nxt = WALK;
                      else if (last_dir == DIR_NS) nxt = EW_G;
                      else                         nxt = NS_G;
                  end
            WALK: if (cnt == WALK_M1) nxt = AR;
`ifdef TRAFFIC_FLASH_MODE_EN
            FLASH: if (!bus.flash) nxt = AR;
`endif
            default: nxt = AR;
        endcase
`ifdef TRAFFIC_FLASH_MODE_EN
        if (bus.flash) nxt = FLASH;
`endif
    end

    // State, phase counter, round-robin direction and the sticky request
    // latches. A request seen in the same cycle as its phase is entered wins
    // over the clear, so it is never dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= NS_G;
            cnt      <= '0;
            ns_pend  <= 1'b0;
            ew_pend  <= 1'b0;
            ped_pend <= 1'b0;
            last_dir <= DIR_NS;
`ifdef TRAFFIC_FLASH_MODE_EN
            flash_on <= 1'b0;
`endif
        end else begin
            state <= nxt;

            if (nxt != state)
                cnt <= '0;
`ifdef TRAFFIC_FLASH_MODE_EN
            else if (state == FLASH && cnt == YEL_M1)
                cnt <= '0;
`endif
            else if (cnt != '1)
                cnt <= cnt + 1'b1;

            if (state == NS_Y && nxt == AR) last_dir <= DIR_NS;
            if (state == EW_Y && nxt == AR) last_dir <= DIR_EW;
`ifdef TRAFFIC_FLASH_MODE_EN
            // Leaving flash hands the first green to N/S.
            if (state == FLASH && nxt == AR) last_dir <= DIR_EW;

            if (nxt == FLASH && state != FLASH)
                flash_on <= 1'b1;
            else if (state == FLASH && nxt == FLASH && cnt == YEL_M1)
                flash_on <= ~flash_on;
`endif

            if (!pend_hold) begin
                if (state != NS_G && bus.ns_req)      ns_pend <= 1'b1;
                else if (state != NS_G && nxt == NS_G) ns_pend <= 1'b0;

                if (state != EW_G && bus.ew_req)      ew_pend <= 1'b1;
                else if (state != EW_G && nxt == EW_G) ew_pend <= 1'b0;

                if (state != WALK && bus.ped_req)      ped_pend <= 1'b1;
                else if (state != WALK && nxt == WALK) ped_pend <= 1'b0;
            end
        end
    end

    // Lamp decode straight from the state register.
    always_comb begin
        bus.n_light = RED;
        bus.s_light = RED;
        bus.e_light = RED;
        bus.w_light = RED;
        bus.walk    = 1'b0;
        case (state)
            NS_G: begin bus.n_light = GREEN;  bus.s_light = GREEN;  end
            NS_Y: begin bus.n_light = YELLOW; bus.s_light = YELLOW; end
            EW_G: begin bus.e_light = GREEN;  bus.w_light = GREEN;  end
            EW_Y: begin bus.e_light = YELLOW; bus.w_light = YELLOW; end
            WALK: bus.walk = 1'b1;
`ifdef TRAFFIC_FLASH_MODE_EN
            FLASH: begin
                bus.n_light = flash_on ? YELLOW : 3'b000;
                bus.s_light = flash_on ? YELLOW : 3'b000;
                bus.e_light = flash_on ? RED    : 3'b000;
                bus.w_light = flash_on ? RED    : 3'b000;
            end
`endif
            default: ;
        endcase
    end

    assign bus.phase = state;

    // Safety invariants: never two axes lit green/yellow at once, and never a
    // green while pedestrians are walking. Dark flash lamps are not "lit".
    logic ns_lit;
    logic ew_lit;
    logic any_green;
    assign ns_lit    = |((bus.n_light | bus.s_light) & (GREEN | YELLOW));
    assign ew_lit    = |((bus.e_light | bus.w_light) & (GREEN | YELLOW));
    assign any_green = |((bus.n_light | bus.s_light | bus.e_light | bus.w_light) & GREEN);

    a_axes_exclusive: assert property (@(posedge clk) disable iff (!rst) !(ns_lit && ew_lit));
    a_no_green_walk:  assert property (@(posedge clk) disable iff (!rst) !(bus.walk && any_green));

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//   Self-checking bench for traffic_phase_scheduler: a directed vector table,
//   hand-written multi-cycle sequences and randomized traffic compared with a
//   phase-level reference model.
//   Optional macro: TRAFFIC_FLASH_MODE_EN enables the flash sequence.
// ---------------------------------------------------------------------------
module tb_traffic_phase_scheduler;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 12;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 2;
    localparam int WALK_T    = 6;

    localparam logic [2:0] P_NS_G = 3'd0;
    localparam logic [2:0] P_NS_Y = 3'd1;
    localparam logic [2:0] P_AR   = 3'd2;
    localparam logic [2:0] P_EW_G = 3'd3;
    localparam logic [2:0] P_EW_Y = 3'd4;
    localparam logic [2:0] P_WALK = 3'd5;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] R = 3'b010;
    localparam logic [2:0] Y = 3'b100;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    traffic_phase_scheduler_if tb_if();

    traffic_phase_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (tb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase name plus an unbounded time-in-phase count.
    logic [2:0] m_phase;
    int         m_time;
    bit         m_ns, m_ew, m_ped;
    bit         m_last_ew;

    typedef struct {
        logic       r;
        logic       ns;
        logic       ew;
        logic       ped;
        logic [2:0] ph;
    } vec_t;

    vec_t tbl[$];

    // Lamp picture the specification gives for each phase.
    function automatic logic [15:0] spec_out(input logic [2:0] ph);
        case (ph)
            P_NS_G:  return {G, G, R, R, 1'b0, ph};
            P_NS_Y:  return {Y, Y, R, R, 1'b0, ph};
            P_EW_G:  return {R, R, G, G, 1'b0, ph};
            P_EW_Y:  return {R, R, Y, Y, 1'b0, ph};
            P_WALK:  return {R, R, R, R, 1'b1, ph};
            default: return {R, R, R, R, 1'b0, ph};
        endcase
    endfunction

    function automatic vec_t mk(input logic r, ns, ew, ped, input logic [2:0] ph);
        vec_t v;
        v.r = r; v.ns = ns; v.ew = ew; v.ped = ped; v.ph = ph;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic ns, input logic ew, input logic ped);
        logic [2:0] np;
        if (!r) begin
            m_phase = P_NS_G; m_time = 0;
            m_ns = 0; m_ew = 0; m_ped = 0; m_last_ew = 0;
            return;
        end
        np = m_phase;
        if (m_phase == P_NS_G) begin
            if (m_time >= MIN_GREEN - 1 && (m_ew || m_ped) && (!ns || m_time >= MAX_GREEN - 1))
                np = P_NS_Y;
        end else if (m_phase == P_EW_G) begin
            if (m_time >= MIN_GREEN - 1 && (m_ns || m_ped) && (!ew || m_time >= MAX_GREEN - 1))
                np = P_EW_Y;
        end else if (m_phase == P_NS_Y || m_phase == P_EW_Y) begin
            if (m_time == YELLOW_T - 1) begin
                np = P_AR;
                m_last_ew = (m_phase == P_EW_Y);
            end
        end else if (m_phase == P_AR) begin
            if (m_time == ALLRED_T - 1)
                np = (m_ped || ped) ? P_WALK : (m_last_ew ? P_NS_G : P_EW_G);
        end else if (m_phase == P_WALK) begin
            if (m_time == WALK_T - 1) np = P_AR;
        end else begin
            np = P_AR;
        end
        if (m_phase != P_NS_G) m_ns  = ns  ? 1'b1 : (np == P_NS_G ? 1'b0 : m_ns);
        if (m_phase != P_EW_G) m_ew  = ew  ? 1'b1 : (np == P_EW_G ? 1'b0 : m_ew);
        if (m_phase != P_WALK) m_ped = ped ? 1'b1 : (np == P_WALK ? 1'b0 : m_ped);
        m_time  = (np == m_phase) ? m_time + 1 : 0;
        m_phase = np;
    endtask

    // Drive one cycle of inputs, clock it in, then settle before sampling.
    task automatic applyStimulus(input logic r, input logic ns, input logic ew, input logic ped);
        rst           = r;
        tb_if.ns_req  = ns;
        tb_if.ew_req  = ew;
        tb_if.ped_req = ped;
        @(posedge clk);
        model_step(r, ns, ew, ped);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] exp);
        logic [15:0] act;
        act = {tb_if.n_light, tb_if.s_light, tb_if.e_light, tb_if.w_light,
               tb_if.walk, tb_if.phase};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got nsew=%b/%b/%b/%b walk=%b phase=%0d, required nsew=%b/%b/%b/%b walk=%b phase=%0d",
                     name, act[15:13], act[12:10], act[9:7], act[6:4], act[3], act[2:0],
                     exp[15:13], exp[12:10], exp[9:7], exp[6:4], exp[3], exp[2:0]);
        end
    endtask

    task automatic wait_phase(input string name, input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (tb_if.phase !== target && n < budget) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (tb_if.phase !== target) begin
            errors++;
            $display("[TB] FAIL %s: phase=%0d, required %0d within %0d cycles",
                     name, tb_if.phase, target, budget);
        end
    endtask

    initial begin
        logic ns_lvl, ew_lvl, ped_b, r_b;

        rst = 1'b0;
        tb_if.ns_req = 1'b0; tb_if.ew_req = 1'b0; tb_if.ped_req = 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
        tb_if.flash = 1'b0;
`endif

        // Reset, gap-out to EW, then a pedestrian served from EW_Y.
        tbl.push_back(mk(0, 0, 0, 0, P_NS_G));
        tbl.push_back(mk(0, 0, 0, 0, P_NS_G));
        tbl.push_back(mk(1, 0, 1, 0, P_NS_G));
        tbl.push_back(mk(1, 0, 0, 0, P_NS_G));
        tbl.push_back(mk(1, 0, 0, 0, P_NS_G));
        tbl.push_back(mk(1, 0, 0, 0, P_NS_Y));
        tbl.push_back(mk(1, 0, 0, 0, P_NS_Y));
        tbl.push_back(mk(1, 0, 0, 0, P_NS_Y));
        tbl.push_back(mk(1, 0, 0, 0, P_AR));
        tbl.push_back(mk(1, 0, 0, 0, P_AR));
        tbl.push_back(mk(1, 0, 0, 0, P_EW_G));
        tbl.push_back(mk(1, 0, 0, 0, P_EW_G));
        tbl.push_back(mk(1, 0, 0, 1, P_EW_G));
        tbl.push_back(mk(1, 0, 0, 0, P_EW_G));
        tbl.push_back(mk(1, 0, 0, 0, P_EW_Y));
        tbl.push_back(mk(1, 0, 0, 0, P_EW_Y));
        tbl.push_back(mk(1, 0, 0, 0, P_EW_Y));
        tbl.push_back(mk(1, 0, 0, 0, P_AR));
        tbl.push_back(mk(1, 0, 0, 0, P_AR));
        for (int i = 0; i < WALK_T; i++) tbl.push_back(mk(1, 0, 0, 0, P_WALK));
        tbl.push_back(mk(1, 0, 0, 0, P_AR));
        tbl.push_back(mk(1, 0, 0, 0, P_AR));
        tbl.push_back(mk(1, 0, 0, 0, P_NS_G));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].r, tbl[i].ns, tbl[i].ew, tbl[i].ped);
            checkOutput($sformatf("table[%0d]", i), spec_out(tbl[i].ph));
        end

        // Resting green with saturation: 63 idle cycles would put a wrapping
        // counter back near zero and delay the gap-out.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("rest_ns_g[%0d]", i), spec_out(P_NS_G));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("sat_latch_cycle", spec_out(P_NS_G));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_immediate_exit", spec_out(P_NS_Y));

        // Max green: N/S demand held, E/W waiting, exactly 12 green cycles.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("maxg_reset", spec_out(P_NS_G));
        for (int k = 1; k < MAX_GREEN; k++) begin
            applyStimulus(1'b1, 1'b1, (k == 1), 1'b0);
            checkOutput($sformatf("maxg_green[%0d]", k), spec_out(P_NS_G));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("maxg_to_yellow", spec_out(P_NS_Y));

        // Reset in the middle of EW_Y with a pedestrian pending.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        wait_phase("reach_ew_g", P_EW_G, 20);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        wait_phase("reach_ew_y", P_EW_Y, 20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("ew_y_ped_latched", spec_out(P_EW_Y));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_mid_ew_y", spec_out(P_NS_G));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("pend_cleared[%0d]", i), spec_out(P_NS_G));
        end

`ifdef TRAFFIC_FLASH_MODE_EN
        // Flash from EW_G, two toggle periods, then release through AR.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        wait_phase("flash_reach_ew_g", P_EW_G, 20);
        tb_if.flash = 1'b1;
        for (int i = 0; i < 4 * YELLOW_T; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            if (((i / YELLOW_T) % 2) == 0)
                checkOutput($sformatf("flash_on[%0d]", i), {Y, Y, R, R, 1'b0, 3'd6});
            else
                checkOutput($sformatf("flash_off[%0d]", i), {3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'd6});
        end
        tb_if.flash = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flash_exit_ar0", spec_out(P_AR));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flash_exit_ar1", spec_out(P_AR));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flash_exit_ns_g", spec_out(P_NS_G));
`endif

        // Randomized traffic against the reference model.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        ns_lvl = 1'b0;
        ew_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ns_lvl = ~ns_lvl;
            if ($urandom_range(0, 7) == 0) ew_lvl = ~ew_lvl;
            ped_b = ($urandom_range(0, 24) == 0);
            r_b   = ($urandom_range(0, 299) != 0);
            applyStimulus(r_b, ns_lvl, ew_lvl, ped_b);
            checkOutput($sformatf("random[%0d]", i), spec_out(m_phase));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-driven phase scheduler for the four-way intersection. Replaces the fixed NS/EW rotation with minimum/maximum green, gap-out, all-red clearance and a pedestrian all-red walk phase.
- Drives the same per-approach light encoding used throughout the intersection design: GREEN=3'b001, RED=3'b010, YELLOW=3'b100.
- Sits between the debounced sensor/button inputs and the lamp drivers.

Parameters:
- MIN_GREEN, 4, minimum green cycles before a competing request is honoured (>=1)
- MAX_GREEN, 12, green cycle cap while a competing request waits (>=MIN_GREEN)
- YELLOW_T, 3, yellow duration in cycles (>=1)
- ALLRED_T, 2, all-red clearance duration in cycles (>=1)
- WALK_T, 6, pedestrian walk duration in cycles (>=1)
- CNT_W, 4, phase counter width; all timing parameters must be <= 2**CNT_W-1

Ports:
- clk, input, 1, system clock; all logic on its rising edge
- rst, input, 1, synchronous reset, active-low (sampled on posedge clk; rst==0 resets)
- ns_req, input, 1, vehicle present on the N or S approach (level)
- ew_req, input, 1, vehicle present on the E or W approach (level)
- ped_req, input, 1, pedestrian button (pulse or level)
- n_light, output, 3, north lamp code
- s_light, output, 3, south lamp code
- e_light, output, 3, east lamp code
- w_light, output, 3, west lamp code
- walk, output, 1, pedestrian walk lamp
- phase, output, 3, current state code (for debug and status)

Behaviour:
- State encoding: NS_G=0, NS_Y=1, AR=2, EW_G=3, EW_Y=4, WALK=5; 6 is reserved for FLASH.
- Outputs are decoded combinationally from the state register only (Moore):
  - NS_G: N=S=GREEN, E=W=RED
  - NS_Y: N=S=YELLOW, E=W=RED
  - EW_G: E=W=GREEN, N=S=RED
  - EW_Y: E=W=YELLOW, N=S=RED
  - AR and WALK: all RED
  - walk=1 only in WALK
- Reset (rst==0 at a posedge):
  - state=NS_G, cnt=0, ns_pend=ew_pend=ped_pend=0, last_dir=NS
  - Outputs therefore read N=S=001, E=W=010, walk=0, phase=0.
  - Reset takes effect from any state, mid-phase included.
- cnt: cycles already spent in the current state. It clears to 0 on every state change and otherwise increments, saturating at all-ones.
- Pending latches are sticky; set has priority over clear within a cycle.
  - ns_pend |= ns_req while not in NS_G; cleared on entry to NS_G.
  - ew_pend |= ew_req while not in EW_G; cleared on entry to EW_G.
  - ped_pend |= ped_req in any state except WALK; cleared on entry to WALK.
- Green exit, shown for NS_G (EW_G is symmetric with ew_req/ns_pend):
  - competing = ew_pend | ped_pend
  - Leave to NS_Y when cnt >= MIN_GREEN-1 AND competing AND (ns_req==0 OR cnt >= MAX_GREEN-1).
  - With no competing request, NS_G rests indefinitely; cnt saturates without wrapping.
- NS_Y -> AR and EW_Y -> AR when cnt == YELLOW_T-1. On entry to AR, last_dir is set to the direction that just lost green.
- AR exits when cnt == ALLRED_T-1. Priority:
  - ped_pend -> WALK
  - else if last_dir==NS -> EW_G
  - else -> NS_G
  - The opposite direction is served even if its pend is 0, because AR is only reached on demand.
- WALK -> AR when cnt == WALK_T-1; last_dir is unchanged. After WALK, the direction opposite last_dir gets green (round robin).
- Simultaneous events:
  - A ped_req arriving in the same cycle as the AR exit is honoured at that exit.
  - Requests arriving during yellow or all-red are latched, never lost.
- Never legal (checked by assertion): both axes non-RED in the same cycle; any GREEN while walk==1.
- Unused or illegal state codes recover to AR on the next clock.

Optional Feature:
- Macro: TRAFFIC_FLASH_MODE_EN
- Defined:
  - Adds input port flash (1 bit, after ped_req).
  - flash==1 forces state FLASH (phase=6) on the next clock from any state; the pending latches hold their values.
  - In FLASH, N/S toggle YELLOW/3'b000 and E/W toggle RED/3'b000, every YELLOW_T cycles (cnt reloads at YELLOW_T-1); walk=0.
  - On flash==0, go to AR with last_dir=EW, so NS_G follows.
- Undefined: no flash port, no FLASH state; code 6 is illegal and recovers to AR.

Test Plan:
- Reset rst=0 for 2 cycles, then rst=1 with no requests -> N/S=001, E/W=010, phase=0 held for 50 cycles; cnt saturates at 15 without wrapping.
- ew_req=1 pulse at cycle 0, ns_req=0 -> NS_G lasts 4 cycles, NS_Y 3, AR 2, then EW_G (E/W=001) starts at cycle 9.
- ns_req held high, ew_req pulsed at cycle 0 -> NS_G extends to exactly 12 cycles (MAX_GREEN), then NS_Y.
- ped_req pulse during EW_Y -> AR, then WALK (walk=1, all lamps 010) for 6 cycles, then AR for 2, then NS_G.
- rst=0 asserted for 1 cycle mid-EW_Y with ped_pend=1 -> next cycle phase=0, N/S=001, pending cleared, no WALK follows.
- (TRAFFIC_FLASH_MODE_EN) flash=1 during EW_G -> phase=6, N/S alternate 100/000 and E/W alternate 010/000 every 3 cycles; flash=0 -> AR for 2 cycles, then NS_G.
